sad_engine: RTL
===============

Name: sad_engine

Overview:
- Parametrised sum-of-absolute-differences engine: FSM controller and datapath in one block.
- Streams two operand arrays from an external dual-read memory with 1-cycle read latency.
- Accumulates |A[i]-B[i]| over a run-time length and reports the result with a go/done handshake.
- Generalises the fixed 32-element SAD controller: width, depth and length are configurable; adds pipelined one-element-per-cycle reads, saturation with overflow flag, and length clamping.

Parameters:
- DATA_W, 8: operand width (unsigned).
- N, 32: maximum element count; 2^ADDR_W >= N required.
- ADDR_W, 5: memory address width.
- SUM_W, 16: accumulator / result width.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  asynchronous active-low reset.
- go  in  1  start request; sampled only in IDLE.
- len  in  ADDR_W+1  element count; latched when go is accepted.
- R_en  out  1  memory read enable.
- addr  out  ADDR_W  read address for both A and B.
- A_data  in  DATA_W  memory A data; valid the cycle after R_en.
- B_data  in  DATA_W  memory B data; valid the cycle after R_en.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse in DONE.
- sad_out  out  SUM_W  accumulated result.
- ovf  out  1  sticky saturation flag for the current run.

Behaviour:
- Reset (Rst=0, asynchronous):
  - State goes to IDLE; R_en, addr, busy, done, sad_out, ovf, index counter and valid pipe all clear to 0.
  - Takes effect immediately, including mid-run; R_en drops without waiting for a clock edge.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On go=1: latch eff_len = min(len, N), clear sum, clear ovf, clear i.
  - eff_len=0 -> DONE directly; otherwise -> RUN.
  - go=0 -> stay in IDLE.
- RUN:
  - R_en=1 and addr=i every cycle; i increments each cycle.
  - When the issued address is eff_len-1, next state is DRAIN.
- DRAIN:
  - R_en=0.
  - Accumulates the final element; next state is DONE.
- DONE:
  - done=1 for exactly one cycle; next state is IDLE unconditionally.
- Datapath pipeline:
  - valid_d is R_en delayed by one cycle.
  - On each edge with valid_d=1: sum <= sat(sum + |A_data - B_data|).
  - The difference is an unsigned DATA_W-bit magnitude, zero-extended to SUM_W.
- Saturation:
  - If the true sum would exceed 2^SUM_W-1, sum becomes all-ones and ovf=1.
  - ovf stays set until the next accepted go; sum stays saturated for the rest of the run.
- Timing (go accepted at edge 0):
  - RUN spans cycles 1..eff_len; DRAIN is cycle eff_len+1; DONE is cycle eff_len+2.
  - Throughput is one element per cycle.
- Output hold:
  - sad_out reflects the sum register at all times.
  - It is final and valid when done=1, and holds until the next accepted go clears it.
- go is ignored while busy=1 and during DONE; no queuing.
- Length clamping: len > N is clamped to N, so at most N addresses are issued.
- len=0: no R_en; done is asserted 1 cycle after go is accepted; sad_out=0, ovf=0.
- addr never exceeds eff_len-1; addr holds its last value outside RUN.

Test Plan:
- Reset values: hold Rst=0 with go=1 toggling -> all outputs 0, no R_en. Release Rst -> state IDLE, outputs stay 0 until go.
- Basic run:
  - Stimulus: len=4, A={10,3,200,0}, B={4,9,100,0}.
  - R_en high exactly 4 cycles with addr 0,1,2,3.
  - done pulses 6 cycles after go is accepted; sad_out=112, ovf=0, busy low after DRAIN.
- Full length: len=32, all A=255, B=0 -> 32 reads; sad_out=8160, ovf=0, done at go+34.
- Saturation: SUM_W=10, len=32, A=255, B=0 -> sad_out=1023, ovf=1; next go with len=1, A=B=5 -> sad_out=0, ovf=0.
- Length edges:
  - len=0 -> no R_en; done at go+1; sad_out=0.
  - len=40 -> clamped to 32 reads, addr max 31.
- Abort and ignore:
  - Rst low at RUN cycle 3 -> R_en, busy, sad_out=0 immediately (before next edge); after release, a fresh len=2 run completes correctly.
  - go pulses during RUN and DONE are ignored: exactly one done per accepted go.

Source files
------------

// File: rtl/sad_engine.sv
// Sum-of-absolute-differences engine: streams A/B operands from a 1-cycle-latency
// memory, accumulates |A[i]-B[i]| with saturation, and reports via a go/done handshake.
module sad_engine #(
  parameter int DATA_W = 8,
  parameter int N      = 32,
  parameter int ADDR_W = 5,
  parameter int SUM_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              go,
  input  logic [ADDR_W:0]   len,
  output logic              R_en,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] A_data,
  input  logic [DATA_W-1:0] B_data,
  output logic              busy,
  output logic              done,
  output logic [SUM_W-1:0]  sad_out,
  output logic              ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [ADDR_W:0] N_LEN = (ADDR_W + 1)'(N);
  localparam logic [ADDR_W:0] ONE   = (ADDR_W + 1)'(1);

  state_t              state_reg;
  state_t              state_next;
  logic [ADDR_W:0]     eff_len_reg;
  logic [ADDR_W-1:0]   idx_reg;
  logic                valid_d_reg;
  logic [SUM_W-1:0]    sum_reg;
  logic                ovf_reg;

  logic                go_accept;
  logic [ADDR_W:0]     len_clamped;
  logic                last_issue;
  logic [DATA_W-1:0]   abs_diff;
  logic [SUM_W:0]      sum_wide;

  assign go_accept   = (state_reg == IDLE) && go;
  assign len_clamped = (len > N_LEN) ? N_LEN : len;
  // The address being issued this cycle is the final one of the run.
  assign last_issue  = (state_reg == RUN) && ({1'b0, idx_reg} == (eff_len_reg - ONE));

  assign abs_diff = (A_data >= B_data) ? (A_data - B_data) : (B_data - A_data);
  assign sum_wide = {1'b0, sum_reg} + (SUM_W + 1)'(abs_diff);

  // State register
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (go) begin
          state_next = (len_clamped == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_issue) begin
          state_next = DRAIN;
        end
      end
      DRAIN:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    R_en = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      RUN: begin
        R_en = 1'b1;
        busy = 1'b1;
      end
      DRAIN:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Index counter doubles as the read address; it holds its last value outside RUN.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      idx_reg     <= '0;
      eff_len_reg <= '0;
    end else if (go_accept) begin
      idx_reg     <= '0;
      eff_len_reg <= len_clamped;
    end else if ((state_reg == RUN) && !last_issue) begin
      idx_reg <= idx_reg + 1'b1;
    end
  end

  assign addr = idx_reg;

  // Memory data for a read issued this cycle arrives next cycle.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      valid_d_reg <= 1'b0;
    end else begin
      valid_d_reg <= R_en;
    end
  end

  // Saturating accumulator; once saturated it stays at all-ones for the run.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sum_reg <= '0;
      ovf_reg <= 1'b0;
    end else if (go_accept) begin
      sum_reg <= '0;
      ovf_reg <= 1'b0;
    end else if (valid_d_reg) begin
      if (sum_wide[SUM_W]) begin
        sum_reg <= '1;
        ovf_reg <= 1'b1;
      end else begin
        sum_reg <= sum_wide[SUM_W-1:0];
      end
    end
  end

  assign sad_out = sum_reg;
  assign ovf     = ovf_reg;

endmodule
